// File: rtl/core_run_ctrl_pkg.sv
// Shared types and constants for the core run sequencer.
package core_run_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CLK_ON,
      GO,
      RUN,
      DRAIN,
      DONE
   } run_state_e;

   typedef enum logic [1:0] {
      NONE    = 2'b00,
      HALTED  = 2'b01,
      TIMEOUT = 2'b10,
      ABORTED = 2'b11
   } run_status_e;

   // jal x0,0 : the program spins on itself to signal completion
   localparam logic [31:0] RV_HALT_JAL = 32'h0000006F;

   function automatic logic core_clk_on(input run_state_e s);
      return (s == CLK_ON) || (s == GO) || (s == RUN) || (s == DRAIN);
   endfunction

endpackage

// File: rtl/UpCounter.sv
// Saturating up-counter with synchronous clear; never wraps past all-ones.
module UpCounter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         clr,
   input  logic         en,
   output logic [W-1:0] count
);

   logic [W-1:0] count_reg;

   always_ff @(posedge clk) begin
      if (!rstn || clr) begin
         count_reg <= '0;
      end else if (en && (count_reg != '1)) begin
         count_reg <= count_reg + 1'b1;
      end
   end

   assign count = count_reg;

endmodule

// File: rtl/run_halt_detect.sv
// Counts consecutive valid decode cycles holding the halt idiom; pulses halt on the last one.
module run_halt_detect
   import core_run_ctrl_pkg::*;
#(
   parameter logic [31:0] HALT_INSTR  = RV_HALT_JAL,
   parameter int          HALT_REPEAT = 2
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        en,
   input  logic        dec_valid,
   input  logic [31:0] dec_instr,
   output logic        halt
);

   localparam int CNT_W = (HALT_REPEAT > 1) ? $clog2(HALT_REPEAT) : 1;
   localparam logic [CNT_W-1:0] LAST_MATCH = CNT_W'(HALT_REPEAT - 1);

   logic [CNT_W-1:0] match_cnt_reg;
   logic             match;

   assign match = dec_valid && (dec_instr == HALT_INSTR);
   // Combinational so the sequencer leaves RUN on the edge that samples the final match
   assign halt  = en && match && (match_cnt_reg == LAST_MATCH);

   always_ff @(posedge clk) begin
      if (!rstn || !en || halt) begin
         match_cnt_reg <= '0;
      end else if (dec_valid) begin
         match_cnt_reg <= match ? match_cnt_reg + 1'b1 : '0;
      end
   end

endmodule

// File: rtl/core_run_ctrl.sv
// Run sequencer: gates the core clock on, fires first fetch, watches for halt/timeout/abort,
// drains the pipeline and gates the clock off again.
module core_run_ctrl
   import core_run_ctrl_pkg::*;
#(
   parameter int          CYCLE_CNT_W     = 32,
   parameter int          WATCHDOG_CYCLES = 5000,
   parameter int          SETTLE_CYCLES   = 10,
   parameter int          DRAIN_CYCLES    = 10,
   parameter logic [31:0] HALT_INSTR      = RV_HALT_JAL,
   parameter int          HALT_REPEAT     = 2
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   start,
   input  logic                   abort,
   input  logic                   dec_valid,
   input  logic [31:0]            dec_instr,
   output logic                   core_clk_en,
   output logic                   first_fetch_trigger,
   output logic                   running,
   output logic                   done,
   output logic [1:0]             status,
   output logic [CYCLE_CNT_W-1:0] cycle_count
);

   localparam logic [31:0] SETTLE_LAST   = 32'(SETTLE_CYCLES - 1);
   localparam logic [31:0] WATCHDOG_LAST = 32'(WATCHDOG_CYCLES - 1);
   localparam logic [31:0] DRAIN_LAST    = 32'(DRAIN_CYCLES - 1);

   run_state_e  state_reg, state_next;
   run_status_e status_reg, status_next;
   // One phase counter serves settle, watchdog and drain since those states never overlap
   logic [31:0] phase_reg, phase_next;
   logic        clr_count;
   logic        halt;
   logic        core_clk_en_reg, first_fetch_reg, running_reg, done_reg;

   run_halt_detect #(
      .HALT_INSTR  (HALT_INSTR),
      .HALT_REPEAT (HALT_REPEAT)
   ) u_halt_detect (
      .clk       (clk),
      .rstn      (rstn),
      .en        (state_reg == RUN),
      .dec_valid (dec_valid),
      .dec_instr (dec_instr),
      .halt      (halt)
   );

   UpCounter #(
      .W (CYCLE_CNT_W)
   ) u_cycle_count (
      .clk   (clk),
      .rstn  (rstn),
      .clr   (clr_count),
      .en    (running_reg),
      .count (cycle_count)
   );

   always_comb begin
      state_next  = state_reg;
      status_next = status_reg;
      phase_next  = phase_reg + 32'd1;
      clr_count   = 1'b0;
      case (state_reg)
         IDLE, DONE: begin
            phase_next = '0;
            if (start) begin
               state_next  = CLK_ON;
               status_next = NONE;
               clr_count   = 1'b1;
            end
         end
         CLK_ON: begin
            if (abort) begin
               state_next  = DRAIN;
               status_next = ABORTED;
               phase_next  = '0;
            end else if (phase_reg == SETTLE_LAST) begin
               state_next = GO;
               phase_next = '0;
            end
         end
         GO: begin
            phase_next = '0;
            if (abort) begin
               state_next  = DRAIN;
               status_next = ABORTED;
            end else begin
               state_next = RUN;
            end
         end
         RUN: begin
            // abort outranks halt, which outranks the watchdog
            if (abort) begin
               state_next  = DRAIN;
               status_next = ABORTED;
               phase_next  = '0;
            end else if (halt) begin
               state_next  = DRAIN;
               status_next = HALTED;
               phase_next  = '0;
            end else if (phase_reg == WATCHDOG_LAST) begin
               state_next  = DRAIN;
               status_next = TIMEOUT;
               phase_next  = '0;
            end
         end
         DRAIN: begin
            if (phase_reg == DRAIN_LAST) begin
               state_next = DONE;
               phase_next = '0;
            end
         end
         default: begin
            state_next = IDLE;
            phase_next = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_reg       <= IDLE;
         status_reg      <= NONE;
         phase_reg       <= '0;
         core_clk_en_reg <= 1'b0;
         first_fetch_reg <= 1'b0;
         running_reg     <= 1'b0;
         done_reg        <= 1'b0;
      end else begin
         state_reg       <= state_next;
         status_reg      <= status_next;
         phase_reg       <= phase_next;
         core_clk_en_reg <= core_clk_on(state_next);
         first_fetch_reg <= (state_next == GO);
         running_reg     <= (state_next == GO) || (state_next == RUN);
         done_reg        <= (state_next == DONE);
      end
   end

   assign core_clk_en         = core_clk_en_reg;
   assign first_fetch_trigger = first_fetch_reg;
   assign running             = running_reg;
   assign done                = done_reg;
   assign status              = status_reg;

endmodule

// File: tb/tb_core_run_ctrl.sv
// Scoreboard bench for core_run_ctrl: each scenario queues its expected outputs per cycle.
module tb_core_run_ctrl;

   localparam int W = 8;

   localparam int S_EN  = 0;
   localparam int S_FF  = 1;
   localparam int S_RUN = 2;
   localparam int S_DN  = 3;
   localparam int S_ST  = 4;
   localparam int S_CNT = 5;

   logic          clk = 1'b0;
   logic          rstn;
   logic          start;
   logic          abort;
   logic          dec_valid;
   logic [31:0]   dec_instr;
   logic          core_clk_en;
   logic          first_fetch_trigger;
   logic          running;
   logic          done;
   logic [1:0]    status;
   logic [W-1:0]  cycle_count;

   core_run_ctrl #(
      .CYCLE_CNT_W     (W),
      .WATCHDOG_CYCLES (20),
      .SETTLE_CYCLES   (2),
      .DRAIN_CYCLES    (3),
      .HALT_INSTR      (32'h0000006F),
      .HALT_REPEAT     (2)
   ) dut (
      .clk                 (clk),
      .rstn                (rstn),
      .start               (start),
      .abort               (abort),
      .dec_valid           (dec_valid),
      .dec_instr           (dec_instr),
      .core_clk_en         (core_clk_en),
      .first_fetch_trigger (first_fetch_trigger),
      .running             (running),
      .done                (done),
      .status              (status),
      .cycle_count         (cycle_count)
   );

   always #5 clk = ~clk;

   int gcyc = 0;
   always @(posedge clk) gcyc <= gcyc + 1;

   typedef struct {
      int          cyc;
      int          sel;
      logic [31:0] val;
      string       tag;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;
   int   base  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s @cycle %0d: got=%0h expected=%0h", tag, gcyc - base, got, exp);
      end
   endtask

   function automatic logic [31:0] dut_sig(input int sel);
      case (sel)
         S_EN:    return {31'd0, core_clk_en};
         S_FF:    return {31'd0, first_fetch_trigger};
         S_RUN:   return {31'd0, running};
         S_DN:    return {31'd0, done};
         S_ST:    return {30'd0, status};
         default: return {{(32-W){1'b0}}, cycle_count};
      endcase
   endfunction

   task automatic push(input int k, input int sel, input logic [31:0] v, input string tag);
      exp_t e;
      e.cyc = base + k;
      e.sel = sel;
      e.val = v;
      e.tag = tag;
      exp_q.push_back(e);
   endtask

   always @(negedge clk) begin
      exp_t e;
      while (exp_q.size() > 0 && exp_q[0].cyc <= gcyc) begin
         e = exp_q.pop_front();
         if (e.cyc < gcyc) check({e.tag, "_missed"}, gcyc, e.cyc);
         else              check(e.tag, dut_sig(e.sel), e.val);
      end
   end

   // Expected outputs, listed in ascending cycle order relative to the start pulse
   task automatic load_expect(input int id);
      case (id)
         0: begin
            push(1, S_EN, 0, "rst_en");   push(1, S_FF, 0, "rst_ff");
            push(1, S_RUN, 0, "rst_run"); push(1, S_DN, 0, "rst_done");
            push(1, S_ST, 0, "rst_st");   push(1, S_CNT, 0, "rst_cnt");
            push(2, S_EN, 0, "rst_idle_en");
         end
         1, 7: begin
            push(1, S_EN, 1, "seq_en_rise"); push(1, S_FF, 0, "seq_ff_c1");
            push(1, S_CNT, 0, "seq_cnt_c1"); push(1, S_ST, 0, "seq_st_c1");
            push(2, S_FF, 0, "seq_ff_c2");   push(2, S_RUN, 0, "seq_run_c2");
            push(3, S_FF, 1, "seq_ff_c3");   push(3, S_RUN, 1, "seq_run_c3");
            push(4, S_FF, 0, "seq_ff_c4");   push(4, S_RUN, 1, "seq_run_c4");
            push(9, S_RUN, 1, "halt_run_c9");
            push(10, S_RUN, 0, "halt_run_c10"); push(10, S_EN, 1, "halt_drain_en");
            push(10, S_ST, 1, "halt_st_c10");
            push(12, S_EN, 1, "halt_drain_end"); push(12, S_DN, 0, "halt_done_c12");
            push(13, S_EN, 0, "halt_en_off");  push(13, S_DN, 1, "halt_done");
            push(13, S_ST, 1, "halt_status");  push(13, S_CNT, 7, "halt_cnt");
         end
         2: begin
            push(1, S_CNT, 0, "wd_cnt_clr"); push(1, S_ST, 0, "wd_st_clr");
            push(3, S_FF, 1, "wd_ff_c3");
            push(23, S_RUN, 1, "wd_run_c23");
            push(24, S_RUN, 0, "wd_run_c24"); push(24, S_ST, 2, "wd_st_c24");
            push(26, S_EN, 1, "wd_drain_end");
            push(27, S_EN, 0, "wd_en_off"); push(27, S_DN, 1, "wd_done");
            push(27, S_ST, 2, "wd_status"); push(27, S_CNT, 21, "wd_cnt");
         end
         3: begin
            push(1, S_CNT, 0, "brk_cnt_clr");
            push(7, S_RUN, 1, "brk_start_ignored");
            push(12, S_RUN, 1, "brk_run_c12");
            push(13, S_RUN, 0, "brk_run_c13"); push(13, S_ST, 1, "brk_st_c13");
            push(13, S_EN, 1, "brk_drain_en");
            push(15, S_EN, 1, "brk_drain_end");
            push(16, S_EN, 0, "brk_en_off"); push(16, S_DN, 1, "brk_done");
            push(16, S_CNT, 10, "brk_cnt");
         end
         4: begin
            push(1, S_EN, 1, "ab_en_c1"); push(2, S_EN, 1, "ab_en_c2");
            push(3, S_FF, 0, "ab_ff_c3"); push(3, S_RUN, 0, "ab_run_c3");
            push(3, S_EN, 1, "ab_drain_en"); push(3, S_ST, 3, "ab_st_c3");
            push(4, S_FF, 0, "ab_ff_c4");
            push(5, S_EN, 1, "ab_drain_end");
            push(6, S_EN, 0, "ab_en_off"); push(6, S_DN, 1, "ab_done");
            push(6, S_ST, 3, "ab_status"); push(6, S_CNT, 0, "ab_cnt");
         end
         5: begin
            push(9, S_RUN, 1, "abh_run_c9");
            push(10, S_RUN, 0, "abh_run_c10"); push(10, S_ST, 3, "abh_st_c10");
            push(13, S_DN, 1, "abh_done"); push(13, S_ST, 3, "abh_status");
            push(13, S_CNT, 7, "abh_cnt");
         end
         6: begin
            push(10, S_ST, 1, "mrst_st_c10"); push(11, S_EN, 1, "mrst_en_c11");
            push(12, S_EN, 0, "mrst_en"); push(12, S_RUN, 0, "mrst_run");
            push(12, S_DN, 0, "mrst_done"); push(12, S_ST, 0, "mrst_st");
            push(12, S_CNT, 0, "mrst_cnt"); push(12, S_FF, 0, "mrst_ff");
            push(14, S_EN, 0, "mrst_idle_en");
         end
         default: ;
      endcase
   endtask

   task automatic drive(input int id, input int k);
      start     = (k == 0) || (id == 3 && k == 6);
      abort     = (id == 4 && k == 2) || (id == 5 && k == 9);
      rstn      = !((id == 6 && k == 11) || (id == 0 && k == 0));
      dec_valid = 1'b0;
      dec_instr = 32'h00000013;
      if (id == 1 || id == 5 || id == 6 || id == 7) begin
         if (k >= 4) dec_valid = 1'b1;
         if (k == 8 || k == 9) dec_instr = 32'h0000006F;
      end else if (id == 2) begin
         dec_valid = 1'b1;
      end else if (id == 3) begin
         case (k)
            8, 10, 12: begin dec_valid = 1'b1; dec_instr = 32'h0000006F; end
            9:         begin dec_valid = 1'b1; dec_instr = 32'h00000013; end
            11:        begin dec_valid = 1'b0; dec_instr = 32'h0000006F; end
            default: ;
         endcase
      end
   endtask

   task automatic run_scn(input int id, input int len);
      @(negedge clk);
      base = gcyc;
      load_expect(id);
      drive(id, 0);
      for (int k = 1; k <= len; k++) begin
         @(negedge clk);
         drive(id, k);
      end
      $display("scenario %0d: %0d cycles, checks=%0d bad=%0d", id, len, total, bad);
   endtask

   initial begin
      rstn      = 1'b0;
      start     = 1'b0;
      abort     = 1'b0;
      dec_valid = 1'b0;
      dec_instr = 32'h0;
      repeat (3) @(negedge clk);
      run_scn(0, 3);
      run_scn(1, 14);
      run_scn(2, 28);
      run_scn(3, 17);
      run_scn(4, 7);
      run_scn(5, 14);
      run_scn(6, 15);
      run_scn(7, 14);
      repeat (3) @(negedge clk);
      check("queue_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/core_run_ctrl.md
Name: core_run_ctrl

Overview:
- Synthesizable run sequencer between the simulation/FPGA harness and CoreTop.
- Sequences the core clock-gate enable and the first-fetch pulse, then watches decode for the halt idiom (jal x0,0 = 32'h0000006F).
- Enforces a cycle watchdog, drains the pipeline, then gates the core clock off.
- Reports a status code and a run cycle count, replacing ad-hoc harness logic.

Parameters:
- CYCLE_CNT_W, 32: width of cycle_count.
- WATCHDOG_CYCLES, 5000: maximum number of cycles in RUN before timeout; must be ≥1.
- SETTLE_CYCLES, 10: cycles with core clock enabled before first fetch; must be ≥1.
- DRAIN_CYCLES, 10: cycles core clock stays enabled after run end; must be ≥1.
- HALT_INSTR, 32'h0000006F: halt instruction encoding.
- HALT_REPEAT, 2: consecutive valid matching decode cycles that declare a halt; must be ≥1.

Ports:
- clk  in  1  free-running clock (ungated).
- rstn  in  1  synchronous active-low reset.
- start  in  1  run request; honoured in IDLE and DONE only.
- abort  in  1  force end of run; honoured in CLK_ON, GO and RUN.
- dec_valid  in  1  decode stage holds a valid instruction.
- dec_instr  in  32  decode stage instruction.
- core_clk_en  out  1  enable to the core ClockGate.
- first_fetch_trigger  out  1  one-cycle pulse to CoreTop.
- running  out  1  high in GO and RUN.
- done  out  1  high in DONE.
- status  out  2  2'b00 none, 2'b01 halted, 2'b10 timeout, 2'b11 aborted.
- cycle_count  out  CYCLE_CNT_W  cycles spent in GO plus RUN.

Behaviour:
- Clock and reset: single clock domain. Reset is synchronous and active-low. All outputs are registered.
- Reset values: state IDLE; all outputs 0. Reset mid-run returns to IDLE with core_clk_en=0 on the next edge and discards status.
- State IDLE: start=1 → CLK_ON. Loads settle counter; clears cycle_count and status.
- State CLK_ON: core_clk_en=1. Stays exactly SETTLE_CYCLES cycles, then → GO.
- State GO: lasts exactly one cycle. first_fetch_trigger=1, core_clk_en=1, then → RUN.
- State RUN: core_clk_en=1.
  - Run counter increments each cycle.
  - Halt counter counts consecutive cycles with dec_valid=1 and dec_instr==HALT_INSTR.
  - A valid non-matching instruction clears the halt counter. dec_valid=0 holds it.
  - When the HALT_REPEAT-th match is sampled → DRAIN with status=01.
  - After WATCHDOG_CYCLES cycles in RUN with no halt → DRAIN with status=10.
- State DRAIN: core_clk_en=1 for exactly DRAIN_CYCLES cycles, then → DONE.
- State DONE: core_clk_en=0, done=1. status and cycle_count hold. start=1 → CLK_ON with status and cycle_count cleared.
- cycle_count: increments on each edge where state is GO or RUN; holds elsewhere. Saturates at all-ones and never wraps.
- Abort: abort=1 in CLK_ON, GO or RUN → DRAIN with status=11. Ignored in IDLE, DRAIN and DONE.
- Priority for simultaneous events in the same cycle: reset > abort > halt > watchdog.
- start outside IDLE/DONE is ignored.
- Latency: start sampled at edge 0 gives core_clk_en=1 from cycle 1 and first_fetch_trigger in cycle 1+SETTLE_CYCLES.

Decomposition:
- Package core_run_ctrl_pkg:
  - run_state_e enum: IDLE, CLK_ON, GO, RUN, DRAIN, DONE.
  - run_status_e enum: NONE, HALTED, TIMEOUT, ABORTED.
  - Constant RV_HALT_JAL = 32'h0000006F.
- cycle_count uses the existing UpCounter, with en = running.
- Halt matching goes in one sub-module, run_halt_detect: inputs dec_valid and dec_instr; consecutive-match counter; outputs a halt pulse.

Test Plan (SETTLE=2, DRAIN=3, WATCHDOG=20, HALT_REPEAT=2, start pulsed at cycle 0):
- Basic sequencing: core_clk_en rises cycle 1; first_fetch_trigger high only in cycle 3; running high from cycle 3.
- Halt: valid 32'h6F presented in cycles 8 and 9 → DRAIN cycles 10–12; done=1, core_clk_en=0 at cycle 13; status=01; cycle_count=7.
- Watchdog: no halt (dec_instr=32'h00000013 valid every cycle) → RUN cycles 4–23, DRAIN 24–26; done at 27; status=10; cycle_count=21.
- Broken halt pattern: 6F valid at 8, 13 at 9, 6F at 10, valid=0 at 11, 6F at 12 → halt detected at 12, DRAIN from 13, status=01.
- Abort and simultaneity: abort at cycle 2 → DRAIN 3–5, status=11, no first_fetch_trigger ever. In a separate run, abort and the 2nd halt match in the same cycle → status=11.
- Reset mid-DRAIN: rstn=0 for one cycle → next cycle IDLE, all outputs 0. A later start in DONE restarts with cycle_count cleared to 0.
